kfps2kb_command_sender: RTL and testbench
=========================================

Name: kfps2kb_command_sender

Overview:
- Host-to-device PS/2 transmitter for the keyboard controller.
- Sends one 8-bit command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) to the keyboard.
- Drives the open-drain clock and data lines with pull-low enables and checks the device ACK bit.
- Asserts `busy` while a transfer is in progress, so the receive path can ignore line activity.

Parameters:
- inhibit_time, 16'd1200: system clocks that the device clock line is held low before the start bit (must cover ≥100 µs).
- start_time, 24'd150000: maximum system clocks from clock release to the first device falling edge.
- over_time, 16'd2000: maximum system clocks between consecutive device falling edges, and while waiting for line release.

Ports:
- clock, in, 1: system clock; all registers update on its falling edge.
- reset, in, 1: asynchronous, active-high.
- device_clock, in, 1: PS/2 clock line as sensed.
- device_data, in, 1: PS/2 data line as sensed.
- device_clock_low, out, 1: 1 = pull clock line low; 0 = release.
- device_data_low, out, 1: 1 = pull data line low; 0 = release.
- send_request, in, 1: request to send `send_data`.
- send_data, in, 8: command byte.
- busy, out, 1: transfer in progress.
- done, out, 1: one-cycle pulse, transfer completed with ACK.
- error, out, 1: one-cycle pulse, transfer failed (timeout or no ACK).

Behaviour:
- Reset (any time, including mid-transfer): `device_clock_low`=0, `device_data_low`=0, `busy`=0, `done`=0, `error`=0; state IDLE; counters cleared; synchronizers preset to 1.
- Line sensing:
  - `device_clock` and `device_data` pass through 2-flop synchronizers.
  - A device falling edge is detected when the previous synced clock is 1 and the current one is 0, i.e. 3 system clocks after the pin edge.
- Handshake:
  - `send_request`=1 while `busy`=0 latches `send_data` and sets `busy`=1 on that same edge.
  - Requests while `busy`=1 are ignored.
  - `busy` falls in the cycle `done` or `error` pulses.
- Parity: odd, parity = ~^data.
- Shift order: bit0 first, then parity, then stop.
- IDLE: both lines released; wait for an accepted request, then go to INHIBIT.
- INHIBIT:
  - `device_clock_low`=1 for `inhibit_time` cycles.
  - In the last cycle set `device_data_low`=1 (start bit) and go to START.
- START:
  - Release the clock, keep data low, load the timeout counter with `start_time`.
  - No device falling edge before expiry -> FAIL.
  - Falling edge 1 -> drive bit0 (`device_data_low` = ~bit); go to SEND with bit index 1.
- SEND, on each device falling edge:
  - Edges 2-8 drive bits 1-7.
  - Edge 9 drives parity.
  - Edge 10 releases data (stop) and moves to ACK.
  - The timeout counter reloads with `over_time` at each edge; expiry -> FAIL.
- ACK:
  - At falling edge 11, sample synced `device_data`.
  - 0 -> RELEASE; 1 -> FAIL.
  - Timeout -> FAIL.
- RELEASE:
  - Wait until synced clock and data are both 1, then pulse `done` and return to IDLE.
  - Timeout (`over_time`) -> FAIL.
- FAIL: release both lines, pulse `error` for one cycle, return to IDLE.
- Output rules:
  - `done` and `error` are never high simultaneously.
  - Neither pulse occurs without a preceding accepted request.
- Timeout counters: saturating down-counters; no wrap.

Test Plan:
- Send 0xED; a device model clocks 11 edges and ACKs low.
  - Required: data bits 1,0,1,1,0,1,1,1, parity 1, stop released.
  - Required: `done` pulses once and `busy` returns to 0.
- Send 0xF4, ACK good.
  - Required: bits 0,0,1,0,1,1,1,1 and parity 0.
  - Required: `device_clock_low` held exactly `inhibit_time` cycles before release.
- Send 0xFF; the device leaves data high at edge 11.
  - Required: `error` pulses, both lines released, `done` stays 0.
- Device stops clocking after edge 5.
  - Required: `error` pulses `over_time` cycles after edge 5.
  - Required: a new request is then accepted normally.
- Device never clocks.
  - Required: `error` pulses `start_time` cycles after clock release.
- Assert `reset` during SEND.
  - Required: all outputs 0 asynchronously.
  - Required: a second `send_request` asserted during `busy` in a separate run is ignored; only one transfer occurs.

Source files
------------

// File: rtl/kfps2kb_command_sender_if.sv
`default_nettype none
// ============================================================================
// Module   : kfps2kb_command_sender_if
// Purpose  : Request handshake and PS/2 line bundle for the command sender.
// Revision : 1.0 - initial release
// ============================================================================
interface kfps2kb_command_sender_if;
    logic       device_clock;
    logic       device_data;
    logic       device_clock_low;
    logic       device_data_low;
    logic       send_request;
    logic [7:0] send_data;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output device_clock, device_data, send_request, send_data,
        input  device_clock_low, device_data_low, busy, done, error
    );

    modport slave (
        input  device_clock, device_data, send_request, send_data,
        output device_clock_low, device_data_low, busy, done, error
    );
endinterface
`default_nettype wire

// File: rtl/kfps2kb_command_sender.sv
`default_nettype none
// ============================================================================
// Module   : kfps2kb_command_sender
// Purpose  : Host-to-device PS/2 transmitter sending one command byte with ACK check.
// Revision : 1.0 - initial release
// ============================================================================
module kfps2kb_command_sender #(
    parameter logic [15:0] inhibit_time = 16'd1200,
    parameter logic [23:0] start_time   = 24'd150000,
    parameter logic [15:0] over_time    = 16'd2000
) (
    input wire logic                  clock,
    input wire logic                  reset,
    kfps2kb_command_sender_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INHIBIT = 3'd1,
        S_START   = 3'd2,
        S_SEND    = 3'd3,
        S_ACK     = 3'd4,
        S_RELEASE = 3'd5,
        S_FAIL    = 3'd6
    } state_t;

    localparam logic [23:0] c_over_load    = {8'd0, over_time};
    localparam logic [23:0] c_inhibit_load = (inhibit_time == 16'd0) ? 24'd0
                                           : ({8'd0, inhibit_time} - 24'd1);

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [3:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  data_q, data_d;
    logic        clk_low_q, clk_low_d;
    logic        data_low_q, data_low_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        dclk_s1_q, dclk_s2_q, dclk_prev_q;
    logic        ddat_s1_q, ddat_s2_q;
    logic        fall_w;
    logic        timeout_w;
    logic        go_fail_w;

    // Synchronizers preset high so reset never fabricates a falling edge.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            dclk_s1_q   <= 1'b1;
            dclk_s2_q   <= 1'b1;
            dclk_prev_q <= 1'b1;
            ddat_s1_q   <= 1'b1;
            ddat_s2_q   <= 1'b1;
        end else begin
            dclk_s1_q   <= bus.device_clock;
            dclk_s2_q   <= dclk_s1_q;
            dclk_prev_q <= dclk_s2_q;
            ddat_s1_q   <= bus.device_data;
            ddat_s2_q   <= ddat_s1_q;
        end
    end

    assign fall_w    = dclk_prev_q & ~dclk_s2_q;
    assign timeout_w = (cnt_q <= 24'd1);

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 24'd0;
            bit_idx_q  <= 4'd0;
            data_q     <= 8'd0;
            clk_low_q  <= 1'b0;
            data_low_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            clk_low_q  <= clk_low_d;
            data_low_q <= data_low_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        data_d     = data_q;
        clk_low_d  = clk_low_q;
        data_low_d = data_low_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        go_fail_w  = 1'b0;

        case (state_q)
            // FAIL lasts the one cycle error is high and accepts requests like IDLE.
            S_IDLE, S_FAIL: begin
                state_d    = S_IDLE;
                clk_low_d  = 1'b0;
                data_low_d = 1'b0;
                if (bus.send_request && !busy_q) begin
                    data_d    = bus.send_data;
                    busy_d    = 1'b1;
                    clk_low_d = 1'b1;
                    cnt_d     = c_inhibit_load;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == 24'd0) begin
                    clk_low_d  = 1'b0;
                    data_low_d = 1'b1;
                    cnt_d      = start_time;
                    state_d    = S_START;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            S_START: begin
                if (fall_w) begin
                    data_low_d = ~data_q[0];
                    bit_idx_d  = 4'd1;
                    cnt_d      = c_over_load;
                    state_d    = S_SEND;
                end else if (timeout_w) begin
                    go_fail_w = 1'b1;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            S_SEND: begin
                if (fall_w) begin
                    cnt_d     = c_over_load;
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q <= 4'd7) begin
                        data_low_d = ~data_q[bit_idx_q[2:0]];
                    end else if (bit_idx_q == 4'd8) begin
                        // Odd parity bit is ~^data, so the pull-low enable is ^data.
                        data_low_d = ^data_q;
                    end else begin
                        data_low_d = 1'b0;
                        state_d    = S_ACK;
                    end
                end else if (timeout_w) begin
                    go_fail_w = 1'b1;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            S_ACK: begin
                if (fall_w) begin
                    if (!ddat_s2_q) begin
                        cnt_d   = c_over_load;
                        state_d = S_RELEASE;
                    end else begin
                        go_fail_w = 1'b1;
                    end
                end else if (timeout_w) begin
                    go_fail_w = 1'b1;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            S_RELEASE: begin
                if (dclk_s2_q && ddat_s2_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (timeout_w) begin
                    go_fail_w = 1'b1;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (go_fail_w) begin
            state_d    = S_FAIL;
            error_d    = 1'b1;
            busy_d     = 1'b0;
            clk_low_d  = 1'b0;
            data_low_d = 1'b0;
        end
    end

    assign bus.device_clock_low = clk_low_q;
    assign bus.device_data_low  = data_low_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.error            = error_q;

endmodule
`default_nettype wire

// File: tb/tb_kfps2kb_command_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_kfps2kb_command_sender
// Purpose  : Directed self-checking bench with an open-drain PS/2 device model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kfps2kb_command_sender;

    localparam logic [15:0] c_inh = 16'd20;
    localparam logic [23:0] c_stt = 24'd300;
    localparam logic [15:0] c_ovt = 16'd50;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    kfps2kb_command_sender_if bus();

    // Wired-AND of host and device pull-downs on each open-drain line.
    assign bus.device_clock = ~(bus.device_clock_low | dev_clk_low);
    assign bus.device_data  = ~(bus.device_data_low  | dev_data_low);

    kfps2kb_command_sender #(
        .inhibit_time (c_inh),
        .start_time   (c_stt),
        .over_time    (c_ovt)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bus.done)              done_cnt <= done_cnt + 1;
        if (bus.error)             err_cnt  <= err_cnt + 1;
        if (bus.done && bus.error) both_cnt <= both_cnt + 1;
    end

    function automatic logic [4:0] outs();
        return {bus.busy, bus.done, bus.error, bus.device_clock_low, bus.device_data_low};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_request(input logic [7:0] d);
        @(posedge clock);
        bus.send_request = 1'b1;
        bus.send_data    = d;
        @(posedge clock);
        bus.send_request = 1'b0;
    endtask

    task automatic wait_release(output int cyc);
        cyc = 0;
        while (bus.device_clock_low && cyc < 1000) begin
            cyc++;
            @(posedge clock);
        end
    endtask

    task automatic dev_edge(input bit ack_low, output logic sampled);
        @(posedge clock);
        if (ack_low) dev_data_low = 1'b1;
        repeat (2) @(posedge clock);
        dev_clk_low = 1'b1;
        repeat (10) @(posedge clock);
        sampled     = bus.device_data;
        dev_clk_low = 1'b0;
    endtask

    task automatic run_frame(input int n, input bit ack_low, output logic [10:0] cap);
        logic s;
        cap = '0;
        for (int k = 0; k < n; k++) begin
            dev_edge(ack_low && (k == 10), s);
            cap[k] = s;
        end
        repeat (3) @(posedge clock);
        dev_data_low = 1'b0;
    endtask

    initial begin
        logic [10:0] cap;
        logic        s;
        int          cyc;

        bus.send_request = 1'b0;
        bus.send_data    = 8'h00;
        repeat (3) @(posedge clock);
        check("reset_outputs", outs(), 5'b0);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        check("idle_outputs", outs(), 5'b0);

        // 0xED, good ACK
        do_request(8'hED);
        check("ed_busy_clk_low", {bus.busy, bus.device_clock_low}, 2'b11);
        wait_release(cyc);
        check("ed_start_bit", bus.device_data_low, 1'b1);
        run_frame(11, 1'b1, cap);
        repeat (10) @(posedge clock);
        check("ed_frame_bits", cap[9:0], 10'h3ED);
        check("ed_done_count", done_cnt, 1);
        check("ed_no_error", err_cnt, 0);
        check("ed_idle_after", outs(), 5'b0);

        // 0xF4, good ACK, exact inhibit length
        do_request(8'hF4);
        wait_release(cyc);
        check("f4_inhibit_cycles", cyc, 20);
        run_frame(11, 1'b1, cap);
        repeat (10) @(posedge clock);
        check("f4_frame_bits", cap[9:0], 10'h2F4);
        check("f4_done_count", done_cnt, 2);

        // 0xFF, device leaves data high at edge 11
        do_request(8'hFF);
        wait_release(cyc);
        run_frame(11, 1'b0, cap);
        repeat (10) @(posedge clock);
        check("ff_frame_bits", cap[9:0], 10'h3FF);
        check("ff_error_count", err_cnt, 1);
        check("ff_no_done", done_cnt, 2);
        check("ff_lines_released", outs(), 5'b0);

        // Device stops clocking after edge 5
        do_request(8'h3C);
        wait_release(cyc);
        for (int k = 0; k < 4; k++) dev_edge(1'b0, s);
        @(posedge clock);
        dev_clk_low = 1'b1;
        cyc = 0;
        while (!bus.error && cyc < 1000) begin
            @(posedge clock);
            cyc++;
            if (cyc == 10) dev_clk_low = 1'b0;
        end
        check("edge5_timeout_cycles", cyc, 53);
        repeat (5) @(posedge clock);
        check("edge5_error_count", err_cnt, 2);
        do_request(8'h55);
        wait_release(cyc);
        run_frame(11, 1'b1, cap);
        repeat (10) @(posedge clock);
        check("retry_frame_bits", cap[9:0], 10'h355);
        check("retry_done_count", done_cnt, 3);

        // Device never clocks
        do_request(8'h00);
        wait_release(cyc);
        cyc = 0;
        while (!bus.error && cyc < 1000) begin
            @(posedge clock);
            cyc++;
        end
        check("start_timeout_cycles", cyc, 300);
        repeat (5) @(posedge clock);
        check("start_error_count", err_cnt, 3);
        check("start_lines_released", outs(), 5'b0);

        // Reset in the middle of SEND
        do_request(8'hA5);
        wait_release(cyc);
        for (int k = 0; k < 3; k++) dev_edge(1'b0, s);
        @(posedge clock);
        check("pre_reset_busy", bus.busy, 1'b1);
        reset = 1'b1;
        #1;
        check("async_reset_outputs", outs(), 5'b0);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) @(posedge clock);
        reset = 1'b0;
        repeat (3) @(posedge clock);

        // Second request while busy is ignored
        do_request(8'h12);
        repeat (3) @(posedge clock);
        bus.send_request = 1'b1;
        bus.send_data    = 8'h34;
        @(posedge clock);
        bus.send_request = 1'b0;
        wait_release(cyc);
        run_frame(11, 1'b1, cap);
        repeat (10) @(posedge clock);
        check("busy_req_frame_bits", cap[9:0], 10'h312);
        check("busy_req_done_count", done_cnt, 4);
        repeat (100) @(posedge clock);
        check("no_second_transfer", {bus.busy, bus.device_clock_low}, 2'b00);
        check("final_done_count", done_cnt, 4);
        check("final_error_count", err_cnt, 3);
        check("done_error_exclusive", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
